// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add unsigned multiplier: one partial-product add and
// right shift of {carry, A, Q} per cycle, n cycles per operation.
module mult_seq_ctrl #(
   parameter int n = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [n-1:0]     multiplicand,
   input  logic [n-1:0]     multiplier,
   output logic             busy,
   output logic             done,
   output logic [2*n-1:0]   product,
   output logic [n-1:0]     pp
);

   localparam int CW = $clog2(n + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e          state_q;
   logic [n-1:0]    m_q, q_q, a_q;
   logic [CW-1:0]   cnt_q;
   logic [2*n-1:0]  product_q;
   logic            busy_q, done_q;

   logic [n:0]      sum_d;
   logic [n-1:0]    a_d, q_d;
   logic [CW-1:0]   cnt_d;

   // The carry lives only in sum_d[n]: after the shift it sits in A's MSB,
   // so a separate carry register would always hold 0.
   always_comb begin
      pp    = (state_q == CALC) ? (m_q & {n{q_q[0]}}) : '0;
      sum_d = {1'b0, a_q} + {1'b0, pp};
      a_d   = sum_d[n:1];
      q_d   = {sum_d[0], q_q[n-1:1]};
      cnt_d = cnt_q + CW'(1);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         m_q       <= '0;
         q_q       <= '0;
         a_q       <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  m_q     <= multiplicand;
                  q_q     <= multiplier;
                  a_q     <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= CALC;
               end
            end
            CALC: begin
               a_q   <= a_d;
               q_q   <= q_d;
               cnt_q <= cnt_d;
               if (cnt_d == CW'(n)) begin
                  product_q <= {a_d, q_d};
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl (n=4): stimulus pushes expected products,
// a negedge monitor pops and compares on every done pulse.
module tb_mult_seq_ctrl;

   localparam int N = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic [N-1:0]     multiplicand = '0;
   logic [N-1:0]     multiplier = '0;
   logic             busy, done;
   logic [2*N-1:0]   product;
   logic [N-1:0]     pp;

   int checks = 0;
   int failures = 0;
   logic [2*N-1:0] exp_q[$];

   mult_seq_ctrl #(.n(N)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product),
      .pp           (pp)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done) begin
         check("busy_with_done", busy, 0);
         if (exp_q.size() == 0) check("spurious_done", done, 0);
         else check("product_on_done", product, exp_q.pop_front());
      end
   end

   // One operation: checks latency, busy length, per-cycle pp and held product.
   // Operands are scrambled after the accepting edge; they must not matter.
   task automatic run_op(input logic [N-1:0] m, input logic [N-1:0] q,
                         input logic [2*N-1:0] exp);
      int cyc = 0;
      int busy_cnt = 0;
      bit seen = 0;
      logic [N-1:0] exp_pp;
      @(negedge clk);
      multiplicand = m;
      multiplier   = q;
      start        = 1'b1;
      exp_q.push_back(exp);
      while (!seen && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            start        = 1'b0;
            multiplicand = N'($urandom);
            multiplier   = N'($urandom);
         end
         if (busy) begin
            busy_cnt++;
            exp_pp = (cyc <= N && q[cyc-1]) ? m : '0;
            check("pp_in_calc", pp, exp_pp);
         end
         if (done) seen = 1;
      end
      check("done_latency", cyc, N + 1);
      check("busy_cycles", busy_cnt, N);
      @(negedge clk);
      check("product_held", product, exp);
      check("pp_idle", pp, 0);
   endtask

   initial begin
      int dones;
      int done_times[$];

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_product", product, 0);
      check("rst_pp", pp, 0);
      reset = 1'b0;

      // Directed vectors, first one right after reset release
      run_op(4'd13, 4'd11, 8'd143);
      run_op(4'd15, 4'd15, 8'd225);
      run_op(4'd0,  4'd9,  8'd0);
      run_op(4'd7,  4'd0,  8'd0);
      run_op(4'd1,  4'd1,  8'd1);

      // start pulsed in CALC cycle 2 with other operands: ignored
      @(negedge clk);
      multiplicand = 4'd13; multiplier = 4'd11; start = 1'b1;
      exp_q.push_back(8'd143);
      dones = 0;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (k == 2) begin start = 1'b1; multiplicand = 4'd2; multiplier = 4'd2; end
         if (k == 3) start = 1'b0;
         if (done) dones++;
      end
      check("ignored_start_dones", dones, 1);
      check("ignored_start_product", product, 143);

      // start held high continuously: done at cycles 5, 11, 17
      @(negedge clk);
      multiplicand = 4'd3; multiplier = 4'd5; start = 1'b1;
      repeat (3) exp_q.push_back(8'd15);
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         if (done) done_times.push_back(k);
      end
      start = 1'b0;
      check("held_start_done_count", done_times.size(), 3);
      if (done_times.size() >= 3) begin
         check("held_done_1", done_times[0], 5);
         check("held_done_2", done_times[1], 11);
         check("held_done_3", done_times[2], 17);
      end
      repeat (2) @(negedge clk);
      check("held_product", product, 15);

      // Reset in CALC cycle 3 aborts with no done and product cleared
      @(negedge clk);
      multiplicand = 4'd9; multiplier = 4'd6; start = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
      end
      check("pre_abort_busy", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_product", product, 0);
      check("abort_pp", pp, 0);
      dones = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("abort_no_done", dones, 0);
      run_op(4'd9, 4'd6, 8'd54);

      // Exhaustive sweep against the bench's own multiply
      for (int m = 0; m < 16; m++)
         for (int q = 0; q < 16; q++)
            run_op(N'(m), N'(q), 8'(m * q));

      // Scoreboard must be fully drained
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
      check("scoreboard_drain", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
